// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types and widths for the memory-bus arbiter slice.
//            - XLEN / BE_W / OP_W : request field widths
//            - id_w()             : requester-index width for N harts
//            - state_t            : arbiter FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = 4;
   localparam int OP_W = 7;

   // Index width for n requesters; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin priority encoder. Returns the lowest
//            requesting index at or after the pointer, wrapping modulo N_IDS.
// Ports    : i_req   [N_IDS]  request vector
//            i_ptr   [ID_W]   round-robin start index (always < N_IDS)
//            o_valid [1]      at least one request present
//            o_idx   [ID_W]   winning index (0 when o_valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
   import bus_pkg::*;
#(
   parameter  int N_IDS = 2,
   localparam int ID_W  = id_w(N_IDS)
) (
   input  logic [N_IDS-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_idx
);

   // One spare bit so ptr + offset cannot overflow before the wrap.
   localparam logic [ID_W:0] c_n = (ID_W+1)'(N_IDS);

   logic [ID_W:0] w_pos;

   // Scan offsets from farthest to nearest so the nearest request to the
   // pointer is the last (and therefore winning) assignment.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int k = N_IDS - 1; k >= 0; k--) begin
         w_pos = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_pos >= c_n) begin
            w_pos = w_pos - c_n;
         end
         if (i_req[w_pos[ID_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_pos[ID_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter in front of the atomic-capable memory
//            controller. Grants one hart at a time, latches its request and
//            routes the controller ack / read data back to that hart only.
// Ports    : i_clk, i_rst (async, active low)
//            hart side  : i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en,
//                         i_atomic, i_operation (flattened per hart),
//                         o_ack (one-hot), o_rd_data (shared)
//            ctrl side  : o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en,
//                         o_atomic, o_id, o_operation, i_ack, i_rd_data
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int N_IDS = 2,
   localparam int ID_W  = id_w(N_IDS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_IDS-1:0]      i_bus_en,
   input  logic [N_IDS-1:0]      i_wr_en,
   input  logic [N_IDS*XLEN-1:0] i_wr_data,
   input  logic [N_IDS*XLEN-1:0] i_addr,
   input  logic [N_IDS*BE_W-1:0] i_byte_en,
   input  logic [N_IDS-1:0]      i_atomic,
   input  logic [N_IDS*OP_W-1:0] i_operation,
   output logic [N_IDS-1:0]      o_ack,
   output logic [XLEN-1:0]       o_rd_data,
   output logic                  o_bus_en,
   output logic                  o_wr_en,
   output logic [XLEN-1:0]       o_wr_data,
   output logic [XLEN-1:0]       o_addr,
   output logic [BE_W-1:0]       o_byte_en,
   output logic                  o_atomic,
   output logic [ID_W-1:0]       o_id,
   output logic [OP_W-1:0]       o_operation,
   input  logic                  i_ack,
   input  logic [XLEN-1:0]       i_rd_data
);

   localparam logic [ID_W-1:0] c_last_id = ID_W'(N_IDS - 1);

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_id;
   logic              r_bus_en_q;
   logic              r_wr_en;
   logic              r_atomic;
   logic [XLEN-1:0]   r_wr_data;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_rd_data;
   logic [BE_W-1:0]   r_byte_en;
   logic [OP_W-1:0]   r_operation;

   logic [N_IDS-1:0]  w_id_oh;
   logic [N_IDS-1:0]  w_mask;
   logic [N_IDS-1:0]  w_req;
   logic              w_grant_vld;
   logic [ID_W-1:0]   w_grant_idx;
   logic              w_ack_fire;

   logic [XLEN-1:0]   w_wr_data_a   [N_IDS];
   logic [XLEN-1:0]   w_addr_a      [N_IDS];
   logic [BE_W-1:0]   w_byte_en_a   [N_IDS];
   logic [OP_W-1:0]   w_operation_a [N_IDS];

   generate
      for (genvar g = 0; g < N_IDS; g++) begin : g_unpack
         assign w_wr_data_a[g]   = i_wr_data[g*XLEN +: XLEN];
         assign w_addr_a[g]      = i_addr[g*XLEN +: XLEN];
         assign w_byte_en_a[g]   = i_byte_en[g*BE_W +: BE_W];
         assign w_operation_a[g] = i_operation[g*OP_W +: OP_W];
      end
   endgenerate

   assign w_id_oh = {{(N_IDS-1){1'b0}}, 1'b1} << r_id;

   // The just-served hart keeps i_bus_en high until it sees its ack; hide it
   // during RELEASE so it cannot be picked up again on that stale request.
   assign w_mask = (r_state == RELEASE) ? w_id_oh : '0;
   assign w_req  = i_bus_en & ~w_mask;

   rr_picker #(
      .N_IDS   (N_IDS)
   ) u_rr_picker (
      .i_req   (w_req),
      .i_ptr   (r_rr_ptr),
      .o_valid (w_grant_vld),
      .o_idx   (w_grant_idx)
   );

   // Acks outside BUSY are protocol errors and are dropped here.
   assign w_ack_fire = (r_state == BUSY) && i_ack;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_bus_en_q  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_atomic    <= 1'b0;
         r_wr_data   <= '0;
         r_addr      <= '0;
         r_rd_data   <= '0;
         r_byte_en   <= '0;
         r_operation <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_vld) begin
                  r_id        <= w_grant_idx;
                  r_wr_en     <= i_wr_en[w_grant_idx];
                  r_atomic    <= i_atomic[w_grant_idx];
                  r_wr_data   <= w_wr_data_a[w_grant_idx];
                  r_addr      <= w_addr_a[w_grant_idx];
                  r_byte_en   <= w_byte_en_a[w_grant_idx];
                  r_operation <= w_operation_a[w_grant_idx];
                  r_bus_en_q  <= 1'b1;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               // Latched fields stay frozen: the controller re-reads addr and
               // wr_data across multi-cycle AMO sequences.
               if (i_ack) begin
                  r_bus_en_q <= 1'b0;
                  r_rd_data  <= i_rd_data;
                  r_rr_ptr   <= (r_id == c_last_id) ? '0 : r_id + 1'b1;
                  r_state    <= RELEASE;
               end
            end
            RELEASE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // The controller is idle again in its ack cycle and samples o_bus_en, so
   // the request must drop combinationally there or it restarts.
   assign o_bus_en    = r_bus_en_q & ~i_ack;
   assign o_ack       = w_ack_fire ? w_id_oh : '0;
   assign o_rd_data   = w_ack_fire ? i_rd_data : r_rd_data;
   assign o_wr_en     = r_wr_en;
   assign o_wr_data   = r_wr_data;
   assign o_addr      = r_addr;
   assign o_byte_en   = r_byte_en;
   assign o_atomic    = r_atomic;
   assign o_id        = r_id;
   assign o_operation = r_operation;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter (N_IDS = 2). The
//            bench plays both the harts and the memory controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          i_rst = 1'b0;
   logic [N-1:0]  i_bus_en = '0;
   logic [N-1:0]  i_wr_en = '0;
   logic [N*32-1:0] i_wr_data = '0;
   logic [N*32-1:0] i_addr = '0;
   logic [N*4-1:0]  i_byte_en = '0;
   logic [N-1:0]  i_atomic = '0;
   logic [N*7-1:0] i_operation = '0;
   logic [N-1:0]  o_ack;
   logic [31:0]   o_rd_data;
   logic          o_bus_en;
   logic          o_wr_en;
   logic [31:0]   o_wr_data;
   logic [31:0]   o_addr;
   logic [3:0]    o_byte_en;
   logic          o_atomic;
   logic [0:0]    o_id;
   logic [6:0]    o_operation;
   logic          i_ack = 1'b0;
   logic [31:0]   i_rd_data = '0;

   int n_pass  = 0;
   int n_total = 0;

   bus_arbiter #(.N_IDS(N)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_bus_en    (i_bus_en),
      .i_wr_en     (i_wr_en),
      .i_wr_data   (i_wr_data),
      .i_addr      (i_addr),
      .i_byte_en   (i_byte_en),
      .i_atomic    (i_atomic),
      .i_operation (i_operation),
      .o_ack       (o_ack),
      .o_rd_data   (o_rd_data),
      .o_bus_en    (o_bus_en),
      .o_wr_en     (o_wr_en),
      .o_wr_data   (o_wr_data),
      .o_addr      (o_addr),
      .o_byte_en   (o_byte_en),
      .o_atomic    (o_atomic),
      .o_id        (o_id),
      .o_operation (o_operation),
      .i_ack       (i_ack),
      .i_rd_data   (i_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
      i_rst = 1'b1;
   endtask

   // Step until the arbiter raises o_bus_en, bounded at 20 cycles.
   task automatic wait_grant(output logic [0:0] id, output bit ok);
      ok = 1'b0;
      id = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_bus_en === 1'b1) begin
            ok = 1'b1;
            id = o_id;
            break;
         end
      end
   endtask

   // Close an ack cycle: clock it in, then drop i_ack and the given requests.
   task automatic end_ack(input logic [N-1:0] drop);
      tick();
      i_ack    = 1'b0;
      i_bus_en = i_bus_en & ~drop;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      n_total++;
      if ({o_bus_en, o_ack, o_id} !== 4'b0000) $display("FAIL reset_ctl: got bus_en/ack/id %b, expected 0000", {o_bus_en, o_ack, o_id});
      else n_pass++;
      n_total++;
      if (o_rd_data !== 32'h0 || o_addr !== 32'h0) $display("FAIL reset_data: got rd_data %h addr %h, expected 0 0", o_rd_data, o_addr);
      else n_pass++;
   endtask

   task automatic test_single();
      i_bus_en[0]    = 1'b1;
      i_wr_en[0]     = 1'b0;
      i_addr[31:0]   = 32'h0000_0100;
      i_byte_en[3:0] = 4'hF;
      tick();
      n_total++;
      if (o_bus_en !== 1'b1) $display("FAIL single_bus_en: got %b, expected 1", o_bus_en);
      else n_pass++;
      n_total++;
      if (o_addr !== 32'h100 || o_id !== 1'b0 || o_wr_en !== 1'b0) $display("FAIL single_fields: got addr %h id %b wr_en %b, expected 100 0 0", o_addr, o_id, o_wr_en);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if (o_ack !== 2'b00 || o_bus_en !== 1'b1) $display("FAIL single_wait: got ack %b bus_en %b, expected 00 1", o_ack, o_bus_en);
      else n_pass++;
      i_ack     = 1'b1;
      i_rd_data = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if (o_ack !== 2'b01 || o_rd_data !== 32'hDEAD_BEEF) $display("FAIL single_ack: got ack %b rd %h, expected 01 deadbeef", o_ack, o_rd_data);
      else n_pass++;
      n_total++;
      if (o_bus_en !== 1'b0) $display("FAIL single_gate: got bus_en %b in ack cycle, expected 0", o_bus_en);
      else n_pass++;
      end_ack(2'b01);
      i_rd_data = 32'h0;
      #1;
      n_total++;
      if (o_ack !== 2'b00 || o_bus_en !== 1'b0 || o_rd_data !== 32'hDEAD_BEEF) $display("FAIL single_release: got ack %b bus_en %b rd %h, expected 00 0 deadbeef", o_ack, o_bus_en, o_rd_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_contention();
      logic [0:0] gid;
      bit ok;
      do_reset();
      i_addr    = {32'h0000_0300, 32'h0000_0200};
      i_bus_en  = 2'b11;
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b0 || o_addr !== 32'h200) $display("FAIL contend_first: got ok %b id %b addr %h, expected 1 0 200", ok, gid, o_addr);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'hA0; #1;
      n_total++;
      if (o_ack !== 2'b01) $display("FAIL contend_ack0: got %b, expected 01", o_ack);
      else n_pass++;
      end_ack(2'b01);
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b1 || o_addr !== 32'h300) $display("FAIL contend_second: got ok %b id %b addr %h, expected 1 1 300", ok, gid, o_addr);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'hB1; #1;
      n_total++;
      if (o_ack !== 2'b10 || o_rd_data !== 32'hB1) $display("FAIL contend_ack1: got ack %b rd %h, expected 10 b1", o_ack, o_rd_data);
      else n_pass++;
      end_ack(2'b10);
      tick();
   endtask

   task automatic test_fairness();
      logic [0:0] exp_seq [3];
      logic [0:0] gid;
      logic [N-1:0] exp_ack;
      logic [N-1:0] drop;
      bit ok;
      exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0;
      i_bus_en = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_grant(gid, ok);
         n_total++;
         if (!ok || gid !== exp_seq[i]) $display("FAIL fair_grant%0d: got ok %b id %b, expected 1 %b", i, ok, gid, exp_seq[i]);
         else n_pass++;
         exp_ack = 2'b01 << exp_seq[i];
         i_ack = 1'b1; i_rd_data = 32'(i); #1;
         n_total++;
         if (o_ack !== exp_ack) $display("FAIL fair_ack%0d: got %b, expected %b", i, o_ack, exp_ack);
         else n_pass++;
         drop = (i == 1) ? 2'b10 : ((i == 2) ? 2'b01 : 2'b00);
         end_ack(drop);
      end
      tick();
   endtask

   task automatic test_amo();
      logic [0:0] gid;
      bit ok;
      i_addr[63:32]      = 32'h40;
      i_wr_data[63:32]   = 32'h5;
      i_wr_en[1]         = 1'b1;
      i_atomic[1]        = 1'b1;
      i_byte_en[7:4]     = 4'hF;
      i_operation[13:7]  = 7'b00000_11;
      i_bus_en           = 2'b10;
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b1 || o_atomic !== 1'b1 || o_operation !== 7'h03) $display("FAIL amo_grant: got ok %b id %b atomic %b op %h, expected 1 1 1 03", ok, gid, o_atomic, o_operation);
      else n_pass++;
      i_addr[63:32]     = 32'h80;
      i_wr_data[63:32]  = 32'h9;
      i_atomic[1]       = 1'b0;
      i_operation[13:7] = 7'h7F;
      tick();
      tick();
      n_total++;
      if (o_addr !== 32'h40 || o_wr_data !== 32'h5) $display("FAIL amo_hold: got addr %h wr_data %h, expected 40 5", o_addr, o_wr_data);
      else n_pass++;
      n_total++;
      if (o_atomic !== 1'b1 || o_operation !== 7'h03 || o_wr_en !== 1'b1 || o_byte_en !== 4'hF) $display("FAIL amo_hold_ctl: got atomic %b op %h wr_en %b be %h, expected 1 03 1 f", o_atomic, o_operation, o_wr_en, o_byte_en);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'h11; #1;
      n_total++;
      if (o_ack !== 2'b10 || o_addr !== 32'h40 || o_id !== 1'b1) $display("FAIL amo_ack: got ack %b addr %h id %b, expected 10 40 1", o_ack, o_addr, o_id);
      else n_pass++;
      end_ack(2'b10);
      i_atomic = '0;
      i_wr_en  = '0;
      tick();
   endtask

   task automatic test_guard();
      logic [0:0] gid;
      bit ok;
      i_addr[31:0] = 32'h500;
      i_bus_en     = 2'b01;
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b0) $display("FAIL guard_grant: got ok %b id %b, expected 1 0", ok, gid);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'hC0C0; #1;
      n_total++;
      if (o_bus_en !== 1'b0 || o_ack !== 2'b01) $display("FAIL guard_ack_cycle: got bus_en %b ack %b, expected 0 01", o_bus_en, o_ack);
      else n_pass++;
      tick();
      i_ack = 1'b0;
      #1;
      n_total++;
      if (o_bus_en !== 1'b0 || o_ack !== 2'b00) $display("FAIL guard_release: got bus_en %b ack %b, expected 0 00", o_bus_en, o_ack);
      else n_pass++;
      tick();
      n_total++;
      if (o_bus_en !== 1'b0) $display("FAIL guard_idle: got bus_en %b, expected 0", o_bus_en);
      else n_pass++;
      tick();
      n_total++;
      if (o_bus_en !== 1'b1 || o_id !== 1'b0) $display("FAIL guard_regrant: got bus_en %b id %b, expected 1 0", o_bus_en, o_id);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'hC0DE; #1;
      end_ack(2'b01);
      tick();
      // Stray ack while idle must be ignored.
      i_ack = 1'b1; i_rd_data = 32'h5555; #1;
      n_total++;
      if (o_ack !== 2'b00 || o_rd_data !== 32'hC0DE) $display("FAIL stray_ack: got ack %b rd %h, expected 00 c0de", o_ack, o_rd_data);
      else n_pass++;
      tick();
      i_ack = 1'b0;
      #1;
      n_total++;
      if (o_bus_en !== 1'b0 || o_rd_data !== 32'hC0DE) $display("FAIL stray_after: got bus_en %b rd %h, expected 0 c0de", o_bus_en, o_rd_data);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [0:0] gid;
      bit ok;
      i_bus_en = 2'b10;
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b1) $display("FAIL areset_pre: got ok %b id %b, expected 1 1", ok, gid);
      else n_pass++;
      #3;
      i_bus_en  = 2'b11;
      i_ack     = 1'b1;
      i_rd_data = 32'h9999;
      i_rst     = 1'b0;
      #1;
      n_total++;
      if ({o_bus_en, o_ack, o_id} !== 4'b0000) $display("FAIL areset_ctl: got bus_en/ack/id %b, expected 0000", {o_bus_en, o_ack, o_id});
      else n_pass++;
      n_total++;
      if (o_rd_data !== 32'h0 || o_addr !== 32'h0) $display("FAIL areset_data: got rd %h addr %h, expected 0 0", o_rd_data, o_addr);
      else n_pass++;
      #2;
      i_ack = 1'b0;
      i_rst = 1'b1;
      wait_grant(gid, ok);
      n_total++;
      if (!ok || gid !== 1'b0) $display("FAIL areset_regrant: got ok %b id %b, expected 1 0", ok, gid);
      else n_pass++;
      i_ack = 1'b1; i_rd_data = 32'h1; #1;
      end_ack(2'b11);
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_amo();
      test_guard();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
